// File: rtl/noise_channel_ctrl.sv
// APU channel 4 (noise) sequencer: NR41/NR42/NR44 state, length counter,
// volume envelope and 15/7-bit LFSR, producing the channel's 4-bit sample.
module noise_channel_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       cpu_en,
  input  logic       slow_clk_en,
  input  logic       apu_on,
  input  logic       reg_write,
  input  logic [1:0] reg_addr,
  input  logic [7:0] reg_wdata,
  input  logic       lfsr_narrow,
  input  logic       next_step,
  input  logic       len_tick,
  input  logic       env_tick,
  output logic [3:0] sample,
  output logic       active,
  output logic [7:0] nr42_q,
  output logic       len_en_q
);

  logic        active_q, active_d;
  logic [7:0]  nr42_d;
  logic        len_en_d;
  logic [6:0]  len_cnt_q, len_cnt_d;
  logic [3:0]  volume_q, volume_d;
  logic [2:0]  env_timer_q, env_timer_d;
  logic        env_done_q, env_done_d;
  logic [14:0] lfsr_q, lfsr_d;

  logic        wr_en;
  logic        wr_nr41;
  logic        wr_nr42;
  logic        wr_nr44;
  logic        trigger;
  logic        dac_on;
  logic [2:0]  env_period;
  logic        lfsr_x;

  assign wr_en      = cpu_en & reg_write;
  assign wr_nr41    = wr_en && (reg_addr == 2'd0);
  assign wr_nr42    = wr_en && (reg_addr == 2'd1);
  assign wr_nr44    = wr_en && (reg_addr == 2'd3);
  assign trigger    = wr_nr44 & reg_wdata[7];
  assign dac_on     = |nr42_q[7:3];
  assign env_period = nr42_q[2:0];
  assign lfsr_x     = lfsr_q[0] ^ lfsr_q[1];

  always_comb begin
    active_d    = active_q;
    nr42_d      = nr42_q;
    len_en_d    = len_en_q;
    len_cnt_d   = len_cnt_q;
    volume_d    = volume_q;
    env_timer_d = env_timer_q;
    env_done_d  = env_done_q;
    lfsr_d      = lfsr_q;

    if (wr_nr44) begin
      len_en_d = reg_wdata[6];
    end

    // Length: an NR41 write or a trigger reload both pre-empt a coincident tick.
    if (wr_nr41) begin
      len_cnt_d = 7'd64 - {1'b0, reg_wdata[5:0]};
    end else if (trigger) begin
      if (len_cnt_q == 7'd0) begin
        len_cnt_d = 7'd64;
      end
    end else if (len_tick && len_en_q && (len_cnt_q != 7'd0)) begin
      len_cnt_d = len_cnt_q - 7'd1;
      if (len_cnt_q == 7'd1) begin
        active_d = 1'b0;
      end
    end

    // Envelope: trigger reload uses the NR42 value held before this edge.
    if (trigger) begin
      volume_d    = nr42_q[7:4];
      env_timer_d = env_period;
      env_done_d  = 1'b0;
    end else if (env_tick && (env_period != 3'd0) && !env_done_q) begin
      if (env_timer_q > 3'd1) begin
        env_timer_d = env_timer_q - 3'd1;
      end else begin
        env_timer_d = env_period;
        if (nr42_q[3]) begin
          if (volume_q == 4'd15) env_done_d = 1'b1;
          else                   volume_d   = volume_q + 4'd1;
        end else begin
          if (volume_q == 4'd0)  env_done_d = 1'b1;
          else                   volume_d   = volume_q - 4'd1;
        end
      end
    end

    if (trigger) begin
      lfsr_d = 15'h7FFF;
    end else if (slow_clk_en && next_step) begin
      lfsr_d = {lfsr_x, lfsr_q[14:1]};
      if (lfsr_narrow) begin
        lfsr_d[6] = lfsr_x;
      end
    end

    if (wr_nr42) begin
      nr42_d = reg_wdata;
      if (reg_wdata[7:3] == 5'd0) begin
        active_d = 1'b0;
      end
    end

    if (trigger) begin
      active_d = dac_on;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || !apu_on) begin
      active_q    <= 1'b0;
      nr42_q      <= 8'd0;
      len_en_q    <= 1'b0;
      len_cnt_q   <= 7'd0;
      volume_q    <= 4'd0;
      env_timer_q <= 3'd0;
      env_done_q  <= 1'b0;
      lfsr_q      <= 15'd0;
    end else begin
      active_q    <= active_d;
      nr42_q      <= nr42_d;
      len_en_q    <= len_en_d;
      len_cnt_q   <= len_cnt_d;
      volume_q    <= volume_d;
      env_timer_q <= env_timer_d;
      env_done_q  <= env_done_d;
      lfsr_q      <= lfsr_d;
    end
  end

  assign active = active_q;
  assign sample = (active_q & dac_on & ~lfsr_q[0]) ? volume_q : 4'd0;

endmodule

// File: doc/noise_channel_ctrl.md
# noise_channel_ctrl

Sequencer for APU channel 4 (noise). It owns the NR41/NR42/NR44 register state, length counter, volume envelope and 15/7-bit LFSR, and produces the channel's 4-bit digital sample. The LFSR is clocked by the `next_step` output of the noise frequency counter. Length and envelope ticks come from the APU frame sequencer. NR43 (clock shift and divisor) is written directly into the frequency counter; only its width bit reaches this block, via `lfsr_narrow`.

## Interface
- No parameters.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `cpu_en` in 1: CPU clock enable; qualifies register writes.
- `slow_clk_en` in 1: APU clock enable; the same enable that drives the frequency counter.
- `apu_on` in 1: NR52 bit 7. While low, the block behaves as reset.
- `reg_write` in 1: register write strobe.
- `reg_addr` in 2: register select. 0 = NR41, 1 = NR42, 3 = NR44. Value 2 is ignored.
- `reg_wdata` in 8: write data.
- `lfsr_narrow` in 1: NR43 bit 3.
- `next_step` in 1: from the frequency counter. Level signal, valid only where `slow_clk_en` is high.
- `len_tick` in 1: 256 Hz frame-sequencer pulse, one clk wide.
- `env_tick` in 1: 64 Hz frame-sequencer pulse, one clk wide.
- `sample` out 4: channel output, 0..15.
- `active` out 1: channel-on flag, reported in NR52 bit 3.
- `nr42_q` out 8: NR42 readback.
- `len_en_q` out 1: NR44 bit 6 readback.

## Operation
- A write is accepted only when `cpu_en & reg_write`.
- **NR41 write:** `len_cnt` (7 bit) <= 64 − `wdata[5:0]`, giving a range of 1..64.
- **NR42 write:** `nr42_q` <= `wdata`.
  - `dac_on` = `nr42_q[7:3]` != 0.
  - If the written value has `wdata[7:3]` == 0, `active` <= 0 in the same edge.
- **NR44 write:** `len_en_q` <= `wdata[6]`. If `wdata[7]` is set, a trigger occurs.
- **Trigger:**
  - `active` <= `dac_on`.
  - If `len_cnt` == 0, `len_cnt` <= 64.
  - `volume` <= `nr42_q[7:4]`.
  - `env_timer` <= `nr42_q[2:0]`.
  - `env_done` <= 0.
  - `lfsr` <= 15'h7FFF.
  - The trigger uses the `nr42_q` value held before the edge.
- **Length:** on `len_tick`, if `len_en_q` and `len_cnt` != 0, `len_cnt` decrements. When the result is 0, `active` <= 0. With `len_cnt` == 0 nothing happens.
- **Envelope** (on `env_tick`):
  - If period (`nr42_q[2:0]`) == 0 or `env_done`: no change.
  - Otherwise, if `env_timer` > 1: `env_timer` decrements.
  - Otherwise, `env_timer` <= period and `volume` steps: +1 if `nr42_q[3]`, else −1.
  - The step saturates. If `volume` is already 15 (increase) or 0 (decrease), `env_done` <= 1 and `volume` is unchanged.
- **LFSR** (on `slow_clk_en & next_step`):
  - x = `lfsr[0]` ^ `lfsr[1]`.
  - `lfsr` <= {x, `lfsr[14:1]`}.
  - If `lfsr_narrow`, `lfsr[6]` is also set to x.
  - The LFSR shifts regardless of `active`.
- **Sample:** `sample` = (`active` & `dac_on` & ~`lfsr[0]`) ? `volume` : 0. Combinational from registered state.

## Timing
- **Reset / !apu_on:** all state is cleared.
  - `sample` = 0, `active` = 0, `nr42_q` = 0, `len_en_q` = 0.
  - `len_cnt` = 0, `volume` = 0, `env_timer` = 0, `env_done` = 0, `lfsr` = 0.
  - Writes are ignored while `apu_on` is low.
  - Reset mid-note silences the channel on the next edge.
- **Latency:** every write, tick or LFSR step takes effect at the clk edge where it is sampled. `sample` and `active` reflect it one clk later.
- **Priority within one edge:** reset > `!apu_on` > register write > tick.
  - **Trigger with `len_tick` in the same edge:** the trigger reload wins and the tick is dropped.
  - **NR41 write with `len_tick`:** the written value wins.
  - **Trigger with `env_tick`:** the trigger wins and the tick is dropped.
  - **Trigger with an LFSR step:** the reload to 7FFF wins.
- **Wrap and saturation:** `len_cnt` never wraps below 0, and `volume` never leaves 0..15.
- **NR44 write without bit 7:** changes only `len_en_q`. Enabling length does not cause an immediate extra clock.

## Test plan
- **Length expiry:** NR42 = F0, NR41 = 3E, NR44 = C0, then 2 `len_tick`s. Required: `active` = 1, `sample` = 15 while `lfsr[0]` = 0. `active` = 0 one clk after the 2nd tick and `sample` = 0.
- **Envelope down:** NR42 = 52 (vol 5, decrease, period 2), trigger, then 10 `env_tick`s. Required: `volume` steps 5→4 at tick 2, then 3, 2, 1, 0 at ticks 4, 6, 8, 10, and holds at 0.
- **Envelope up and saturation:** NR42 = E9 (vol 14, increase, period 1), trigger, then 3 `env_tick`s. Required: `volume` = 15 after tick 1, unchanged after ticks 2 and 3, `env_done` = 1.
- **LFSR sequence:** NR42 = F0, trigger, `lfsr_narrow` = 0, 4 qualified `next_step`s. Required: `lfsr` = 3FFF, 1FFF, 0FFF, 07FF. Repeat with `lfsr_narrow` = 1 and check `lfsr` = 3FBF after the first step. `next_step` with `slow_clk_en` = 0 causes no shift.
- **DAC off:** NR42 = 07 while the channel is active. Required: `active` = 0 the next clk. A trigger with NR42 = 07 leaves `active` = 0.
- **Collision and power:** a trigger coincident with `len_tick` at `len_cnt` = 0 gives `len_cnt` = 64. Then `apu_on` = 0 gives all outputs 0 the next clk, and an NR42 write while off leaves `nr42_q` = 0.
